bin27_to_bcd8: RTL and testbench

Sequential binary-to-BCD converter turning a 27-bit unsigned count (0..99_999_999) into eight packed BCD digits for the eight-digit HC595 seven-segment display path. It sits between the 8-digit number source and the segment scan/serializer. It uses a shift-and-add-3 (double-dabble) engine, one bit per clock, with a start/busy/done handshake. The last result is held stable between conversions.

---
 rtl/bin27_to_bcd8.sv | 137 +++++++++++++
 tb/tb_bin27_to_bcd8.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bin27_to_bcd8.sv
// bin27_to_bcd8: sequential 27-bit binary to 8-digit packed BCD converter.
// One double-dabble iteration per clock, 27 iterations per conversion.
// The result (bcd_o/ovf_o) is held stable between conversions.
// Values above NUM_MAX still take the full 27 iterations, then saturate to
// 9999_9999 and set ovf_o.
module bin27_to_bcd8 #(
  parameter int                  BIN_W   = 27,
  parameter logic [BIN_W-1:0]    NUM_MAX = 27'd99_999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      bcd_o,
  output logic             ovf_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more, all nibbles in parallel,
  // so that the following left shift carries correctly into the next digit.
  function automatic logic [31:0] dabble_adj(input logic [31:0] acc);
    logic [31:0] res;
    res = acc;
    for (int i = 0; i < 8; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [31:0]        acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               ovfp_q, ovfp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        acc_adj_s;
  logic [31+BIN_W:0]  shifted_s;

  // Next-state logic: IDLE accepts a request, SHIFT runs one iteration per clock.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovfp_d    = ovfp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    acc_adj_s = dabble_adj(acc_q);
    // Corrections are applied before the shift; the top bit of shreg enters acc[0].
    shifted_s = {acc_adj_s, shreg_q} << 1;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          shreg_d = bin_i;
          acc_d   = 32'h0000_0000;
          cnt_d   = 5'd0;
          ovfp_d  = (bin_i > NUM_MAX);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        busy_d  = 1'b1;
        acc_d   = shifted_s[31+BIN_W:BIN_W];
        shreg_d = shifted_s[BIN_W-1:0];
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd26) begin
          // Final iteration: publish the result and return to IDLE so a held
          // start is accepted on the very next edge.
          bcd_d   = ovfp_q ? 32'h9999_9999 : shifted_s[31+BIN_W:BIN_W];
          ovf_d   = ovfp_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      acc_q   <= 32'h0000_0000;
      cnt_q   <= 5'd0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 32'h0000_0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_bin27_to_bcd8.sv
// Directed self-checking bench for bin27_to_bcd8.
module tb_bin27_to_bcd8;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [26:0] bin_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] bcd_o;
  logic        ovf_o;

  int checks   = 0;
  int failures = 0;

  bin27_to_bcd8 dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bcd_o   (bcd_o),
    .ovf_o   (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, saturated above 99_999_999.
  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    r = 32'h0;
    t = v;
    if (v > 32'd99_999_999) begin
      r = 32'h9999_9999;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count rising edges until done_o is seen (sampled 1 time unit after the edge).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!done_o && n < 60);
  endtask

  // One full conversion with a single-cycle start pulse; bin changes after acceptance.
  task automatic conv(input logic [26:0] v, input string tag);
    int n;
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = v;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    bin_i   = v ^ 27'h555_5555;
    chk({tag, "_busy_run"}, 32'(busy_o), 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'd27);
    chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
    chk({tag, "_bcd"}, bcd_o, ref_bcd(32'(v)));
    chk({tag, "_ovf"}, 32'(ovf_o), (v > 27'd99_999_999) ? 32'd1 : 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int pulses;
    logic [26:0] rv;
    rst     = 1'b0;
    start_i = 1'b0;
    bin_i   = 27'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_bcd", bcd_o, 32'h0000_0000);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);
    chk("idle_bcd", bcd_o, 32'h0000_0000);

    // Main function and boundaries
    conv(27'd0, "zero");
    conv(27'd12_345_678, "c12345678");
    conv(27'd99_999_999, "max");
    @(posedge clk);
    #1;
    chk("done_width", 32'(done_o), 32'd0);
    conv(27'd100_000_000, "over");
    repeat (5) @(negedge clk);
    chk("hold_bcd", bcd_o, 32'h9999_9999);
    chk("hold_ovf", 32'(ovf_o), 32'd1);
    conv(27'd5, "five");

    // start and bin change while busy: ignored
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 27'd24_681_357;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 27'd1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_restart_busy", 32'(busy_o), 32'd1);
    wait_done(n);
    chk("busy_restart_lat", 32'(n + 5), 32'd27);
    chk("busy_restart_bcd", bcd_o, 32'h2468_1357);

    // Back-to-back conversions with start held high
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 27'd31_415_926;
    @(posedge clk);
    wait_done(n);
    chk("b2b_lat1", 32'(n), 32'd27);
    chk("b2b_bcd1", bcd_o, 32'h3141_5926);
    wait_done(n);
    chk("b2b_gap2", 32'(n), 32'd28);
    chk("b2b_bcd2", bcd_o, 32'h3141_5926);
    wait_done(n);
    chk("b2b_gap3", 32'(n), 32'd28);
    chk("b2b_bcd3", bcd_o, 32'h3141_5926);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("b2b_stop_busy", 32'(busy_o), 32'd0);

    // Reset in the middle of a conversion
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 27'd87_654_321;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_bcd", bcd_o, 32'h0000_0000);
    chk("abort_ovf", 32'(ovf_o), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    conv(27'd87_654_321, "after_abort");

    // Digit-rollover corners
    conv(27'd9, "c9");
    conv(27'd10, "c10");
    conv(27'd99_999, "c99999");
    conv(27'd100_000, "c100000");
    conv(27'h7FF_FFFF, "allones");

    // Random sweep over the valid range
    for (int k = 0; k < 1500; k++) begin
      rv = 27'($urandom_range(99_999_999, 0));
      conv(rv, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
